// File: rtl/thirty_two_bit_restoring_divider.sv
// ============================================================================
// thirty_two_bit_restoring_divider
//
// Multi-cycle unsigned divider using the restoring (trial subtraction)
// algorithm, one quotient bit per clock. An operation accepted while idle
// (or in the done cycle) runs WIDTH iterations and then pulses done for one
// cycle. quotient / remainder / div_by_zero are registered and hold their
// value until the next result is produced or rst is asserted.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   start        operation request, honoured only while busy is low
//   dividend     numerator, captured with an accepted start
//   divisor      denominator, captured with an accepted start
//   busy         high while iterating
//   done         one-cycle pulse, results valid
//   quotient     floor(dividend / divisor); all ones when divisor is 0
//   remainder    dividend mod divisor; equals dividend when divisor is 0
//   div_by_zero  set together with done when the divisor was 0
//
// Build option
//   DIVIDER_DIVZERO_FAST_EN  when defined, a zero divisor is detected at
//                            start and the result is produced in one cycle
//                            with div_by_zero = 1. When undefined, a zero
//                            divisor runs the full iteration count and
//                            div_by_zero stays 0.
// ============================================================================
module thirty_two_bit_restoring_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

`ifdef DIVIDER_DIVZERO_FAST_EN
    localparam bit FAST_ZERO = 1'b1;
`else
    localparam bit FAST_ZERO = 1'b0;
`endif

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    count;

    // Iteration registers: partial remainder, dividend/quotient shift
    // register, and the captured divisor.
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] q_acc;
    logic [WIDTH-1:0] d_reg;

    logic             accept;
    logic             zero_fast;
    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_next;
    logic [WIDTH-1:0] q_next;

    // busy is high exactly in RUN, so this also covers "IDLE or DONE".
    assign accept    = start && !busy;
    assign zero_fast = FAST_ZERO && (divisor == '0);

    // ------------------------------------------------------------------------
    // One restoring step. After k steps the partial remainder is below 2^k
    // and below the divisor, so the shifted remainder always fits in WIDTH
    // bits and r_acc's MSB is 0 here; the WIDTH+1-bit subtraction only needs
    // its top bit as the borrow (negative trial) indicator.
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a value on every path first,
        // otherwise synthesis infers a latch to hold the old value.
        r_shift = {r_acc[WIDTH-2:0], q_acc[WIDTH-1]};
        q_next  = {q_acc[WIDTH-2:0], 1'b0};
        r_next  = r_shift;
        trial   = {r_acc, q_acc[WIDTH-1]} - {1'b0, d_reg};
        if (!trial[WIDTH]) begin
            r_next    = trial[WIDTH-1:0];
            q_next[0] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath. Its contents are only meaningful after an accepted start
    // loads them, so they carry no reset.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: no reset on these registers on purpose -- the FSM never looks
        // at them until a start has initialised them, and leaving the reset
        // off keeps the wide datapath free of reset routing.
        if (accept) begin
            d_reg <= divisor;
            q_acc <= dividend;
            r_acc <= '0;
        end else if (state == RUN) begin
            r_acc <= r_next;
            q_acc <= q_next;
        end
    end

    // ------------------------------------------------------------------------
    // Control FSM with registered handshake and result outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples values from before this edge, independent of
        // statement order.
        if (rst) begin
            state       <= IDLE;
            count       <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                    if (start) begin
                        if (zero_fast) begin
                            // Result is known immediately; skip iterating.
                            state       <= DONE;
                            done        <= 1'b1;
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                            count <= CW'(WIDTH);
                        end
                    end
                end

                RUN: begin
                    count <= count - 1'b1;
                    // Last iteration: publish the step's result directly.
                    if (count == CW'(1)) begin
                        state       <= DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        quotient    <= q_next;
                        remainder   <= r_next;
                        div_by_zero <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_thirty_two_bit_restoring_divider.sv
module tb_thirty_two_bit_restoring_divider;

    localparam int WIDTH = 32;
    localparam int LIMIT = 45;

`ifdef DIVIDER_DIVZERO_FAST_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int tests_run = 0;
    int tests_failed = 0;

    // Last result the model expects to be visible on the outputs.
    logic [WIDTH-1:0] held_q = '0;
    logic [WIDTH-1:0] held_r = '0;

    thirty_two_bit_restoring_divider #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at the negedge of cycle 0: request the operation, advance to
    // cycle 1 (start is then driven per cycle by wait_done).
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Observes cycles 1.. until done, optionally pulsing an extra start
    // (which must be ignored) in cycle pulse_at. Returns at the negedge of
    // the done cycle, or after LIMIT cycles with done_cyc = 0.
    task automatic wait_done(input int pulse_at,
                             input logic [WIDTH-1:0] pa, input logic [WIDTH-1:0] pb,
                             output int done_cyc, output int busy_cnt,
                             output logic busy_at_done, output int hold_bad);
        done_cyc     = 0;
        busy_cnt     = 0;
        busy_at_done = 1'b0;
        hold_bad     = 0;
        for (int c = 1; c <= LIMIT; c++) begin
            if (done) begin
                done_cyc     = c;
                busy_at_done = busy;
                break;
            end
            if (busy) busy_cnt++;
            if (quotient !== held_q || remainder !== held_r) hold_bad++;
            start = (c == pulse_at);
            if (c == pulse_at) begin
                dividend = pa;
                divisor  = pb;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    // Compares the finished operation against plain-arithmetic expectations.
    task automatic check_result(input string name,
                                input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input int done_cyc, input int busy_cnt,
                                input logic busy_at_done, input int hold_bad);
        logic [WIDTH-1:0] exp_q;
        logic [WIDTH-1:0] exp_r;
        logic             exp_z;
        int               exp_lat;
        int               exp_busy;
        exp_q    = (b == 0) ? '1 : a / b;
        exp_r    = (b == 0) ? a : a % b;
        exp_z    = FAST && (b == 0);
        exp_lat  = exp_z ? 1 : WIDTH + 1;
        exp_busy = exp_z ? 0 : WIDTH;
        check({name, " latency"}, WIDTH'(done_cyc), WIDTH'(exp_lat));
        check({name, " busy_cycles"}, WIDTH'(busy_cnt), WIDTH'(exp_busy));
        check({name, " busy_at_done"}, WIDTH'(busy_at_done), '0);
        check({name, " quotient"}, quotient, exp_q);
        check({name, " remainder"}, remainder, exp_r);
        check({name, " div_by_zero"}, WIDTH'(div_by_zero), WIDTH'(exp_z));
        check({name, " held_before_done"}, WIDTH'(hold_bad), '0);
        held_q = exp_q;
        held_r = exp_r;
    endtask

    // Full operation started from idle; afterwards checks the done pulse is
    // one cycle wide and leaves the bench at the negedge of an idle cycle.
    task automatic run_op(input string name,
                          input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        int   dc, bc, hb;
        logic bd;
        issue(a, b);
        wait_done(0, '0, '0, dc, bc, bd, hb);
        check_result(name, a, b, dc, bc, bd, hb);
        @(negedge clk);
        check({name, " done_one_cycle"}, WIDTH'(done), '0);
    endtask

    initial begin
        int   dc, bc, hb, extra;
        logic bd;
        logic [WIDTH-1:0] ra, rb;

        rst      = 1'b1;
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;

        // Reset with start held high: reset wins.
        repeat (3) @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        check("reset busy", WIDTH'(busy), '0);
        check("reset done", WIDTH'(done), '0);
        check("reset quotient", quotient, '0);
        check("reset remainder", remainder, '0);
        check("reset div_by_zero", WIDTH'(div_by_zero), '0);
        @(negedge clk);
        check("reset start_dropped", WIDTH'(busy), '0);

        // Directed cases.
        run_op("100/7", 32'd100, 32'd7);
        run_op("max/1", 32'hFFFF_FFFF, 32'd1);
        run_op("3/10", 32'd3, 32'd10);
        run_op("msb/max", 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("5/0", 32'd5, 32'd0);
        run_op("max/max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);

        // Start while busy is ignored; no second done appears.
        issue(32'd100, 32'd7);
        wait_done(10, 32'd50, 32'd5, dc, bc, bd, hb);
        check_result("ignored_start", 32'd100, 32'd7, dc, bc, bd, hb);
        extra = 0;
        for (int c = 0; c < LIMIT; c++) begin
            @(negedge clk);
            if (done) extra++;
        end
        check("ignored_start no_second_done", WIDTH'(extra), '0);

        // Back-to-back: second start issued in the done cycle.
        issue(32'd100, 32'd7);
        wait_done(0, '0, '0, dc, bc, bd, hb);
        check_result("b2b first", 32'd100, 32'd7, dc, bc, bd, hb);
        issue(32'd50, 32'd5);
        wait_done(0, '0, '0, dc, bc, bd, hb);
        check_result("b2b second", 32'd50, 32'd5, dc, bc, bd, hb);
        @(negedge clk);

        // Reset in cycle 10 aborts the operation without a done pulse.
        issue(32'd100, 32'd7);
        for (int c = 1; c < 10; c++) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort busy", WIDTH'(busy), '0);
        check("abort done", WIDTH'(done), '0);
        check("abort quotient", quotient, '0);
        check("abort remainder", remainder, '0);
        check("abort div_by_zero", WIDTH'(div_by_zero), '0);
        held_q = '0;
        held_r = '0;
        extra = 0;
        for (int c = 0; c < LIMIT; c++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        check("abort no_done", WIDTH'(extra), '0);

        // Randomized operands, mixing wide, narrow and zero divisors.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = $urandom_range(1, 255);
                2:       rb = $urandom >> $urandom_range(0, 31);
                default: rb = (i % 8 == 0) ? '0 : $urandom_range(1, 65535);
            endcase
            run_op($sformatf("rand%0d", i), ra, rb);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
